// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the iterative execute-stage ALU.
//   - 4-bit operation codes, also used by the ALU control decoder
//   - FSM state encoding alu_state_t
//   - small classification helpers for the op codes
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLL   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_BRCMP = 4'b1010;
    localparam logic [3:0] ALU_CTZ   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    // Shifts are the only ops that walk a bit count down to zero.
    function automatic logic is_shift(input logic [3:0] ctl);
        return (ctl == ALU_SLL) || (ctl == ALU_SRL) || (ctl == ALU_SRA);
    endfunction

    function automatic logic is_ctz(input logic [3:0] ctl);
        return (ctl == ALU_CTZ);
    endfunction

endpackage

// File: rtl/alu_iter_if.sv
// alu_iter_if: request/response bundle between operand fetch, the ALU and
// writeback.
//   master: drives in_valid, alu_ctl, op_a, op_b, out_ready
//   slave : drives in_ready, out_valid, result, zero
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. While
// out_valid is high and out_ready low, result and zero hold their values.
// Request fields only matter in the transfer cycle.
interface alu_iter_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output in_valid, alu_ctl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, alu_ctl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_basic.sv
// alu_basic: combinational single-cycle ALU datapath.
//   ctl_i : operation code (alu_pkg codes)
//   a_i   : operand A
//   b_i   : operand B
//   res_o : result; 0 for shift/CTZ/undefined codes (those are handled,
//           or defined as zero, by the caller)
module alu_basic
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      ctl_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] res_o
);

    logic [XLEN-1:0] diff;
    logic            lt_s;
    logic            lt_u;

    assign diff = a_i - b_i;
    assign lt_s = $signed(a_i) < $signed(b_i);
    assign lt_u = a_i < b_i;

    always_comb begin
        res_o = '0;
        case (ctl_i)
            ALU_ADD:   res_o = a_i + b_i;
            ALU_SUB:   res_o = diff;
            ALU_AND:   res_o = a_i & b_i;
            ALU_OR:    res_o = a_i | b_i;
            ALU_XOR:   res_o = a_i ^ b_i;
            ALU_SLT:   res_o = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU:  res_o = {{(XLEN-1){1'b0}}, lt_u};
            // The branch unit only looks at zero, so a-b is enough.
            ALU_BRCMP: res_o = diff;
            default:   res_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_iter.sv
// alu_iter: multi-cycle execute-stage ALU.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   bus     : alu_iter_if slave (request in, result out)
//   state_o : current FSM state, for observation
// Simple ops finish in one cycle via alu_basic. Shifts move one bit per
// cycle; CTZ shifts right one bit per cycle counting zeros, so neither
// needs a barrel shifter or a priority encoder.
module alu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_iter_if.slave  bus,
    output alu_state_t state_o
);

    localparam int SHW = $clog2(XLEN);
    // One extra bit so the CTZ count can reach XLEN itself.
    localparam int CW  = SHW + 1;

    alu_state_t      state_q;
    logic [3:0]      op_q;
    logic [XLEN-1:0] work_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;

    logic [XLEN-1:0] basic_res;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] work_step;
    logic [CW-1:0]   cnt_dec;
    logic [CW-1:0]   cnt_inc;
    logic            in_ready;

    alu_basic #(.XLEN(XLEN)) u_basic (
        .ctl_i (bus.alu_ctl),
        .a_i   (bus.op_a),
        .b_i   (bus.op_b),
        .res_o (basic_res)
    );

    assign shamt   = bus.op_b[SHW-1:0];
    assign cnt_dec = cnt_q - 1'b1;
    assign cnt_inc = cnt_q + 1'b1;

    // One-bit move of the working register for the op held in op_q.
    always_comb begin
        work_step = work_q;
        case (op_q)
            ALU_SLL: work_step = {work_q[XLEN-2:0], 1'b0};
            ALU_SRL: work_step = {1'b0, work_q[XLEN-1:1]};
            ALU_SRA: work_step = {work_q[XLEN-1], work_q[XLEN-1:1]};
            ALU_CTZ: work_step = {1'b0, work_q[XLEN-1:1]};
            default: work_step = work_q;
        endcase
    end

    // Both handshake outputs depend on state alone, so neither out_ready nor
    // in_valid has a combinational path to the other side.
    assign in_ready      = (state_q == IDLE);
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign state_o       = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= ALU_ADD;
            work_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready) begin
                        op_q <= bus.alu_ctl;
                        if (is_shift(bus.alu_ctl)) begin
                            if (shamt == '0) begin
                                result_q <= bus.op_a;
                                zero_q   <= (bus.op_a == '0);
                                state_q  <= DONE;
                            end else begin
                                work_q  <= bus.op_a;
                                cnt_q   <= {1'b0, shamt};
                                state_q <= BUSY;
                            end
                        end else if (is_ctz(bus.alu_ctl)) begin
                            if (bus.op_a[0]) begin
                                result_q <= '0;
                                zero_q   <= 1'b1;
                                state_q  <= DONE;
                            end else begin
                                work_q  <= bus.op_a;
                                cnt_q   <= '0;
                                state_q <= BUSY;
                            end
                        end else begin
                            result_q <= basic_res;
                            zero_q   <= (basic_res == '0);
                            state_q  <= DONE;
                        end
                    end
                end

                BUSY: begin
                    work_q <= work_step;
                    if (is_ctz(op_q)) begin
                        cnt_q <= cnt_inc;
                        // Stop on the first set bit, or after XLEN steps
                        // when the source was all zeros.
                        if (work_step[0] || (cnt_inc == CW'(XLEN))) begin
                            result_q <= XLEN'(cnt_inc);
                            zero_q   <= (cnt_inc == '0);
                            state_q  <= DONE;
                        end
                    end else begin
                        cnt_q <= cnt_dec;
                        if (cnt_dec == '0) begin
                            result_q <= work_step;
                            zero_q   <= (work_step == '0);
                            state_q  <= DONE;
                        end
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
